// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: register-file geometry, word types and
// the ALU operation encodings used by ALU control.
package mips_pkg;

  localparam int REG_W      = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_W-1:0]      word_t;

  localparam reg_addr_t REG_ZERO = '0;

  // ALU operation encodings (consumed by ALU control and the ALU)
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

endpackage

// File: rtl/reg_file_rd_port.sv
// One combinational read port: $0 forced to zero, optional write-through
// bypass of the data being written this cycle.
module reg_file_rd_port
  import mips_pkg::*;
#(
  parameter int WIDTH  = REG_W,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int BYPASS = 1
) (
  input  logic [ADDR_W-1:0] ra,
  input  logic [WIDTH-1:0]  mem_data,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [WIDTH-1:0]  wd,
  input  logic              rst_n,
  output logic [WIDTH-1:0]  rd
);

  // Zero register wins, then bypass (never during reset), else stored value
  always_comb begin
    rd = mem_data;
    if (ra == '0) begin
      rd = '0;
    end else if ((BYPASS != 0) && rst_n && we && (ra == wa)) begin
      rd = wd;
    end
  end

endmodule

// File: rtl/reg_file.sv
// MIPS general-purpose register file: two combinational read ports, one
// clocked write port, $0 hardwired to zero.
module reg_file
  import mips_pkg::*;
#(
  parameter int WIDTH  = REG_W,
  parameter int DEPTH  = 2 ** REG_ADDR_W,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [WIDTH-1:0]  rd1,
  output logic [WIDTH-1:0]  rd2,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [WIDTH-1:0]  wd
);

  // mem[i] holds architectural register i+1; register 0 has no storage
  logic [WIDTH-1:0] mem  [DEPTH-1];
  // Full address-indexed view with entry 0 tied to zero
  logic [WIDTH-1:0] view [DEPTH];

  // Reset clears every register and drops any concurrent write; writes to $0 vanish
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (!rst_n) begin
        mem[i] <= '0;
      end else if (we && (wa == ADDR_W'(i + 1))) begin
        mem[i] <= wd;
      end
    end
  end

  // Build the address-indexed view used by both read ports
  always_comb begin
    view[0] = '0;
    for (int i = 1; i < DEPTH; i++) begin
      view[i] = mem[i-1];
    end
  end

  reg_file_rd_port #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W),
    .BYPASS (BYPASS)
  ) u_rd_port1 (
    .ra       (ra1),
    .mem_data (view[ra1]),
    .we       (we),
    .wa       (wa),
    .wd       (wd),
    .rst_n    (rst_n),
    .rd       (rd1)
  );

  reg_file_rd_port #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W),
    .BYPASS (BYPASS)
  ) u_rd_port2 (
    .ra       (ra2),
    .mem_data (view[ra2]),
    .we       (we),
    .wa       (wa),
    .wd       (wd),
    .rst_n    (rst_n),
    .rd       (rd2)
  );

endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: a bypassing and a non-bypassing instance share all
// inputs; expected read data is queued when stimulus is driven and popped
// when outputs are sampled on the falling edge.
module tb_reg_file;

  logic        clk;
  logic        rst_n;
  logic [4:0]  ra1, ra2, wa;
  logic        we;
  logic [31:0] wd;
  logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;

  logic [31:0] exp_q[$];
  logic [31:0] obs [4];
  logic [31:0] model [32];
  logic [31:0] exp_v;
  int          vec_cnt;
  int          err_cnt;

  reg_file #(.BYPASS(1)) dut_b (
    .clk (clk), .rst_n (rst_n),
    .ra1 (ra1), .ra2 (ra2), .rd1 (rd1_b), .rd2 (rd2_b),
    .we  (we),  .wa  (wa),  .wd  (wd)
  );

  reg_file #(.BYPASS(0)) dut_n (
    .clk (clk), .rst_n (rst_n),
    .ra1 (ra1), .ra2 (ra2), .rd1 (rd1_n), .rd2 (rd2_n),
    .we  (we),  .wa  (wa),  .wd  (wd)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    obs[0] = rd1_b;
    obs[1] = rd2_b;
    obs[2] = rd1_n;
    obs[3] = rd2_n;
  end

  // advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // push expectations: bypass rd1, rd2, then non-bypass rd1, rd2
  task automatic expect4(input logic [31:0] b1, input logic [31:0] b2,
                         input logic [31:0] n1, input logic [31:0] n2);
    exp_q.push_back(b1);
    exp_q.push_back(b2);
    exp_q.push_back(n1);
    exp_q.push_back(n2);
  endtask

  // drive a write and mirror it into the model after the edge
  task automatic write_cycle(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1;
    wa = a;
    wd = d;
    step();
    if (a != 5'd0) model[a] = d;
    we = 1'b0;
  endtask

  task automatic test_reset();
    ra1 = 5'd0; ra2 = 5'd0; we = 1'b0; wa = 5'd0; wd = '0; rst_n = 1'b1;
    #2;
    expect4(32'h0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      exp_v = exp_q.pop_front();
      vec_cnt++;
      if (obs[k] !== exp_v) begin
        err_cnt++;
        $display("FAIL reset_pre_zero port%0d got %h expected %h", k, obs[k], exp_v);
      end
    end
    // reset with a write pending: the write must be lost
    rst_n = 1'b0; we = 1'b1; wa = 5'd7; wd = 32'hCAFE_F00D;
    step();
    step();
    rst_n = 1'b1; we = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = '0;
    for (int a = 0; a < 32; a++) begin
      ra1 = 5'(a);
      ra2 = 5'(a) ^ 5'h1f;
      expect4(32'h0, 32'h0, 32'h0, 32'h0);
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        exp_v = exp_q.pop_front();
        vec_cnt++;
        if (obs[k] !== exp_v) begin
          err_cnt++;
          $display("FAIL reset_sweep a=%0d port%0d got %h expected %h", a, k, obs[k], exp_v);
        end
      end
      step();
    end
  endtask

  task automatic test_write_read();
    we = 1'b1; wa = 5'd5; wd = 32'hDEAD_BEEF; ra1 = 5'd5; ra2 = 5'd6;
    expect4(32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      exp_v = exp_q.pop_front();
      vec_cnt++;
      if (obs[k] !== exp_v) begin
        err_cnt++;
        $display("FAIL wr_same_cycle port%0d got %h expected %h", k, obs[k], exp_v);
      end
    end
    step();
    model[5] = 32'hDEAD_BEEF;
    we = 1'b0; ra1 = 5'd5; ra2 = 5'd5;
    expect4(32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      exp_v = exp_q.pop_front();
      vec_cnt++;
      if (obs[k] !== exp_v) begin
        err_cnt++;
        $display("FAIL wr_next_cycle port%0d got %h expected %h", k, obs[k], exp_v);
      end
    end
    ra1 = 5'd6; ra2 = 5'd4;
    expect4(32'h0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      exp_v = exp_q.pop_front();
      vec_cnt++;
      if (obs[k] !== exp_v) begin
        err_cnt++;
        $display("FAIL wr_neighbours port%0d got %h expected %h", k, obs[k], exp_v);
      end
    end
    step();
  endtask

  task automatic test_zero_write();
    we = 1'b1; wa = 5'd0; wd = 32'hFFFF_FFFF; ra1 = 5'd0; ra2 = 5'd5;
    expect4(32'h0, 32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      exp_v = exp_q.pop_front();
      vec_cnt++;
      if (obs[k] !== exp_v) begin
        err_cnt++;
        $display("FAIL zero_wr_same port%0d got %h expected %h", k, obs[k], exp_v);
      end
    end
    step();
    we = 1'b0;
    // nothing may have changed anywhere
    for (int a = 0; a < 32; a++) begin
      ra1 = 5'(a);
      ra2 = 5'd0;
      expect4(model[a], 32'h0, model[a], 32'h0);
      #2;
      for (int k = 0; k < 4; k++) begin
        exp_v = exp_q.pop_front();
        vec_cnt++;
        if (obs[k] !== exp_v) begin
          err_cnt++;
          $display("FAIL zero_wr_after a=%0d port%0d got %h expected %h", a, k, obs[k], exp_v);
        end
      end
    end
    step();
  endtask

  task automatic test_bypass();
    we = 1'b1; wa = 5'd9; wd = 32'h1234_5678; ra1 = 5'd9; ra2 = 5'd9;
    expect4(32'h1234_5678, 32'h1234_5678, 32'h0, 32'h0);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      exp_v = exp_q.pop_front();
      vec_cnt++;
      if (obs[k] !== exp_v) begin
        err_cnt++;
        $display("FAIL bypass_before port%0d got %h expected %h", k, obs[k], exp_v);
      end
    end
    step();
    model[9] = 32'h1234_5678;
    we = 1'b0;
    expect4(32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      exp_v = exp_q.pop_front();
      vec_cnt++;
      if (obs[k] !== exp_v) begin
        err_cnt++;
        $display("FAIL bypass_after port%0d got %h expected %h", k, obs[k], exp_v);
      end
    end
    step();
  endtask

  task automatic test_fill();
    logic [4:0] pa [3];
    logic [4:0] pb [3];
    pa[0] = 5'd1;  pb[0] = 5'd31;
    pa[1] = 5'd17; pb[1] = 5'd17;
    pa[2] = 5'd31; pb[2] = 5'd1;
    for (int a = 1; a < 32; a++) begin
      we = 1'b1; wa = 5'(a); wd = 32'(a) * 32'h0101_0101;
      ra1 = 5'(a); ra2 = 5'(a - 1);
      expect4(32'(a) * 32'h0101_0101, model[a - 1], model[a], model[a - 1]);
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        exp_v = exp_q.pop_front();
        vec_cnt++;
        if (obs[k] !== exp_v) begin
          err_cnt++;
          $display("FAIL fill_wr a=%0d port%0d got %h expected %h", a, k, obs[k], exp_v);
        end
      end
      step();
      model[a] = 32'(a) * 32'h0101_0101;
    end
    we = 1'b0;
    for (int p = 0; p < 3; p++) begin
      ra1 = pa[p]; ra2 = pb[p];
      expect4(32'(pa[p]) * 32'h0101_0101, 32'(pb[p]) * 32'h0101_0101,
              32'(pa[p]) * 32'h0101_0101, 32'(pb[p]) * 32'h0101_0101);
      #2;
      for (int k = 0; k < 4; k++) begin
        exp_v = exp_q.pop_front();
        vec_cnt++;
        if (obs[k] !== exp_v) begin
          err_cnt++;
          $display("FAIL fill_pair p=%0d port%0d got %h expected %h", p, k, obs[k], exp_v);
        end
      end
    end
    for (int r = 0; r < 12; r++) begin
      ra1 = 5'($urandom_range(0, 31));
      ra2 = 5'($urandom_range(0, 31));
      expect4(model[ra1], model[ra2], model[ra1], model[ra2]);
      #2;
      for (int k = 0; k < 4; k++) begin
        exp_v = exp_q.pop_front();
        vec_cnt++;
        if (obs[k] !== exp_v) begin
          err_cnt++;
          $display("FAIL fill_rand ra1=%0d ra2=%0d port%0d got %h expected %h", ra1, ra2, k, obs[k], exp_v);
        end
      end
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] d0, d1;
    d0 = $urandom_range(1, 32'h7fff_ffff);
    d1 = d0 ^ 32'h8000_0001;
    ra1 = 5'd12; ra2 = 5'd13;
    write_cycle(5'd12, d0);
    we = 1'b1; wa = 5'd12; wd = d1;
    expect4(d1, model[13], d0, model[13]);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      exp_v = exp_q.pop_front();
      vec_cnt++;
      if (obs[k] !== exp_v) begin
        err_cnt++;
        $display("FAIL b2b_second port%0d got %h expected %h", k, obs[k], exp_v);
      end
    end
    step();
    model[12] = d1;
    we = 1'b0;
    expect4(d1, model[13], d1, model[13]);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      exp_v = exp_q.pop_front();
      vec_cnt++;
      if (obs[k] !== exp_v) begin
        err_cnt++;
        $display("FAIL b2b_last_wins port%0d got %h expected %h", k, obs[k], exp_v);
      end
    end
    step();
  endtask

  task automatic test_reset_mid();
    ra1 = 5'd3; ra2 = 5'd3;
    write_cycle(5'd3, 32'hA5A5_A5A5);
    rst_n = 1'b0; we = 1'b1; wa = 5'd3; wd = 32'h0000_0001;
    // bypass suppressed during reset: stored value shows on both instances
    expect4(32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'hA5A5_A5A5);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      exp_v = exp_q.pop_front();
      vec_cnt++;
      if (obs[k] !== exp_v) begin
        err_cnt++;
        $display("FAIL rst_no_bypass port%0d got %h expected %h", k, obs[k], exp_v);
      end
    end
    step();
    for (int i = 0; i < 32; i++) model[i] = '0;
    rst_n = 1'b1; we = 1'b0;
    for (int a = 0; a < 32; a++) begin
      ra1 = 5'(a);
      ra2 = 5'd31 - 5'(a);
      expect4(32'h0, 32'h0, 32'h0, 32'h0);
      #2;
      for (int k = 0; k < 4; k++) begin
        exp_v = exp_q.pop_front();
        vec_cnt++;
        if (obs[k] !== exp_v) begin
          err_cnt++;
          $display("FAIL rst_mid_clear a=%0d port%0d got %h expected %h", a, k, obs[k], exp_v);
        end
      end
    end
    step();
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    for (int i = 0; i < 32; i++) model[i] = '0;
    test_reset();
    test_write_read();
    test_zero_write();
    test_bypass();
    test_fill();
    test_back_to_back();
    test_reset_mid();
    if (exp_q.size() != 0) begin
      err_cnt++;
      $display("FAIL scoreboard_drain left %0d expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/reg_file.md
# reg_file

Three-port MIPS general-purpose register file: two combinational read ports and one clocked write port. It sits directly upstream of the ALU, supplying its `a` and `b` operands from instruction fields rs/rt. It captures the writeback result at the end of each cycle. Register $0 is hardwired to zero, and an optional write-through bypass returns same-cycle write data to the readers.

## Interface
- `WIDTH`, 32, data width of each register and of all data ports.
- `DEPTH`, 32, number of registers; must be a power of two.
- `ADDR_W`, $clog2(DEPTH), address width; derived, not overridden.
- `BYPASS`, 1, 1 = a read of the address being written this cycle returns `wd`; 0 = it returns the stored (old) value.
- `clk` input 1 — single clock; all state updates on rising edge.
- `rst_n` input 1 — reset; synchronous, active-low.
- `ra1` input ADDR_W — read address port 1 (rs).
- `ra2` input ADDR_W — read address port 2 (rt).
- `rd1` output WIDTH — read data port 1; feeds ALU `a`.
- `rd2` output WIDTH — read data port 2; feeds ALU `b` / store data.
- `we` input 1 — write enable.
- `wa` input ADDR_W — write address (rd/rt per instruction).
- `wd` input WIDTH — write data (ALU result or load data).

## Operation
- Storage: DEPTH × WIDTH registers; entry 0 is not implemented as state.
- Reset:
  - On a rising edge with `rst_n`=0, every register 1..DEPTH-1 clears to 0.
  - `we` is ignored on that edge.
  - A write requested on the reset edge is lost.
- Write:
  - On a rising edge with `rst_n`=1, `we`=1 and `wa`≠0, `mem[wa]` ← `wd`.
  - `wa`=0 writes are discarded silently.
  - `we`=0 leaves all state unchanged.
- Read (combinational, both ports identical and independent):
  - `ra`=0 → 0, regardless of writes or bypass.
  - `BYPASS`=1 and `rst_n`=1 and `we`=1 and `ra`=`wa`≠0 → `wd`.
  - Otherwise → `mem[ra]`.
- While `rst_n`=0:
  - Bypass is suppressed.
  - Reads return stored contents, which are 0 from the second reset cycle on.
- Both read ports may address the same register, each other's address, or the write address simultaneously; no conflicts, no priority issues.
- No X propagation: all storage is reset, so every read after the first reset edge is defined.

## Timing
- Read latency: 0 cycles (pure combinational path `ra`→`rd`, and `wd`→`rd` when bypass is taken).
- Write latency: 1 edge. Data written at edge N is visible via storage from just after edge N.
  - With `BYPASS`=1 it is also visible in the cycle before edge N.
  - With `BYPASS`=0 the readers see the old value until edge N.
- Reset value of outputs:
  - `rd1`/`rd2` = 0 for any address once one reset edge has occurred.
  - Before the first reset edge only address 0 is defined.
- Reset mid-operation: a reset edge overrides a simultaneous write; contents are all zero on the next cycle.
- Back-to-back writes to the same address: last one wins, one per edge.
- Write followed by read in the next cycle: returns the new value (both `BYPASS` settings).

## Structure
- Shared package `mips_pkg`:
  - `REG_W` (32) and `REG_ADDR_W` (5).
  - `typedef logic [REG_ADDR_W-1:0] reg_addr_t`.
  - `typedef logic [REG_W-1:0] word_t`.
  - `localparam reg_addr_t REG_ZERO = '0`.
- ALU op encodings belong in `mips_pkg` too (shared with ALU control); not used here.
- Sub-module `reg_file_rd_port`: zero-check plus bypass mux for one read port, instantiated twice (ports: `ra`, `mem_data`, `we`, `wa`, `wd`, `rst_n` → `rd`).
- Storage array and write logic live in `reg_file` itself.

## Test plan
- Reset, then sweep `ra1`/`ra2` over 0..31 → every read returns 0x00000000.
- Write 0xDEADBEEF to reg 5 (`we`=1, `wa`=5), next cycle `ra1`=5, `ra2`=5 → both 0xDEADBEEF; reg 6 still reads 0.
- `we`=1, `wa`=0, `wd`=0xFFFFFFFF, with `ra1`=0 same cycle and next cycle → 0 both times; no other register changes.
- Same-cycle write 0x12345678 to reg 9 with `ra1`=9:
  - `BYPASS`=1: `rd1`=0x12345678 before the edge.
  - `BYPASS`=0: `rd1`=old value 0 before the edge, 0x12345678 after.
- Fill regs 1..31 with value = address × 0x01010101, read pairs (1,31), (17,17), (31,1) → correct values on both ports independently.
- Reg 3 = 0xA5A5A5A5, then assert `rst_n`=0 on the same edge as a write of 0x1 to reg 3 → next cycle reg 3 reads 0; no bypass of 0x1 while `rst_n`=0.
